// File: rtl/vx_kmu_pkg.sv
// Shared KMU definitions: DCR register map, launch descriptor and writer FSM states.
// The KMU receiver decodes DCR addresses against these same register indices.
package vx_kmu_pkg;

    localparam int VX_DCR_ADDR_WIDTH = 12;
    localparam int VX_DCR_DATA_WIDTH = 32;

    localparam logic [3:0] KMU_REG_PC_LO    = 4'd0;
    localparam logic [3:0] KMU_REG_PC_HI    = 4'd1;
    localparam logic [3:0] KMU_REG_GRID_X   = 4'd2;
    localparam logic [3:0] KMU_REG_GRID_Y   = 4'd3;
    localparam logic [3:0] KMU_REG_GRID_Z   = 4'd4;
    localparam logic [3:0] KMU_REG_BLOCK_X  = 4'd5;
    localparam logic [3:0] KMU_REG_BLOCK_Y  = 4'd6;
    localparam logic [3:0] KMU_REG_BLOCK_Z  = 4'd7;
    localparam logic [3:0] KMU_REG_PARAM_LO = 4'd8;
    localparam logic [3:0] KMU_REG_PARAM_HI = 4'd9;
    localparam logic [3:0] KMU_REG_START    = 4'd10;

    localparam int KMU_NUM_REGS = 11;
    // Registers below START carry descriptor data and have a shadow copy.
    localparam int KMU_NUM_CFG  = 10;

    typedef struct packed {
        logic [63:0]       pc;
        logic [2:0][31:0]  grid_dim;
        logic [2:0][31:0]  block_dim;
        logic [63:0]       param;
    } kmu_launch_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT
    } kmu_state_e;

    function automatic logic [31:0] kmu_reg_value(input kmu_launch_t d, input logic [3:0] idx);
        case (idx)
            KMU_REG_PC_LO:    return d.pc[31:0];
            KMU_REG_PC_HI:    return d.pc[63:32];
            KMU_REG_GRID_X:   return d.grid_dim[0];
            KMU_REG_GRID_Y:   return d.grid_dim[1];
            KMU_REG_GRID_Z:   return d.grid_dim[2];
            KMU_REG_BLOCK_X:  return d.block_dim[0];
            KMU_REG_BLOCK_Y:  return d.block_dim[1];
            KMU_REG_BLOCK_Z:  return d.block_dim[2];
            KMU_REG_PARAM_LO: return d.param[31:0];
            KMU_REG_PARAM_HI: return d.param[63:32];
            default:          return 32'h1;
        endcase
    endfunction

endpackage

// File: rtl/vx_kmu_dirty_sel.sv
// Lowest-set-bit priority encoder over the dirty register mask.
// Purely combinational; empty_o flags that nothing remains to be written.
module vx_kmu_dirty_sel
    import vx_kmu_pkg::*;
(
    input  logic [KMU_NUM_REGS-1:0] dirty_i,
    output logic [3:0]              idx_o,
    output logic                    empty_o
);

    // Scanning downward lets the lowest set bit win the final assignment.
    always_comb begin
        idx_o = '0;
        for (int i = KMU_NUM_REGS - 1; i >= 0; i--) begin
            if (dirty_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

    assign empty_o = ~|dirty_i;

endmodule

// File: rtl/vx_kmu_launch_writer.sv
// Serializes a kernel launch descriptor into DCR writes (changed fields only), then START,
// then waits out a busy holdoff and for the KMU to go idle. One write per cycle, no DCR backpressure.
module vx_kmu_launch_writer
    import vx_kmu_pkg::*;
#(
    parameter int                             XLEN         = 32,
    parameter logic [VX_DCR_ADDR_WIDTH-1:0]   DCR_BASE     = 12'h100,
    parameter int                             BUSY_HOLDOFF = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          launch_valid,
    output logic                          launch_ready,
    input  logic [XLEN-1:0]               launch_pc,
    input  logic [95:0]                   launch_grid_dim,
    input  logic [95:0]                   launch_block_dim,
    input  logic [XLEN-1:0]               launch_param,
    output logic                          dcr_wr_valid,
    output logic [VX_DCR_ADDR_WIDTH-1:0]  dcr_wr_addr,
    output logic [VX_DCR_DATA_WIDTH-1:0]  dcr_wr_data,
    input  logic                          kmu_busy,
    output logic                          launch_done,
    output logic                          launch_err
);

    localparam int                 HOLD_W   = $clog2(BUSY_HOLDOFF + 2);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(BUSY_HOLDOFF);

    kmu_state_e               state_q, state_d;
    kmu_launch_t              in_desc;
    kmu_launch_t              desc_q;
    logic [KMU_NUM_REGS-1:0]  dirty_q;
    logic [KMU_NUM_REGS-1:0]  new_dirty;
    logic [31:0]              shadow_q [KMU_NUM_CFG];
    logic [KMU_NUM_CFG-1:0]   shadow_vld_q;
    logic [HOLD_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic                     err_q;

    logic                     dims_ok;
    logic                     handshake;
    logic                     accept;
    logic                     reject;
    logic [3:0]               wr_idx;
    logic                     dirty_empty;
    logic                     write_fire;
    logic                     hold_done;

    // Dims are packed x in [31:0], y in [63:32], z in [95:64].
    always_comb begin
        in_desc       = '0;
        in_desc.pc    = 64'(launch_pc);
        in_desc.param = 64'(launch_param);
        for (int i = 0; i < 3; i++) begin
            in_desc.grid_dim[i]  = launch_grid_dim[32*i +: 32];
            in_desc.block_dim[i] = launch_block_dim[32*i +: 32];
        end
    end

    always_comb begin
        dims_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (in_desc.grid_dim[i] == '0 || in_desc.block_dim[i] == '0) begin
                dims_ok = 1'b0;
            end
        end
    end

    assign handshake = launch_valid && (state_q == IDLE);
    assign accept    = handshake && dims_ok;
    assign reject    = handshake && !dims_ok;

    // A field is dirty if its shadow was never written or no longer matches.
    always_comb begin
        new_dirty = '0;
        for (int i = 0; i < KMU_NUM_CFG; i++) begin
            new_dirty[i] = !shadow_vld_q[i] ||
                           (shadow_q[i] != kmu_reg_value(in_desc, 4'(i)));
        end
        if (XLEN <= 32) begin
            new_dirty[KMU_REG_PC_HI]    = 1'b0;
            new_dirty[KMU_REG_PARAM_HI] = 1'b0;
        end
        new_dirty[KMU_REG_START] = 1'b1;
    end

    vx_kmu_dirty_sel u_dirty_sel (
        .dirty_i (dirty_q),
        .idx_o   (wr_idx),
        .empty_o (dirty_empty)
    );

    assign write_fire = (state_q == WRITE) && !dirty_empty;
    assign hold_done  = (hold_cnt_q == HOLD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (dirty_empty) begin
                    state_d = IDLE;
                end else if (wr_idx == KMU_REG_START) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (hold_done && !kmu_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        launch_ready = (state_q == IDLE);
        dcr_wr_valid = write_fire;
        dcr_wr_addr  = '0;
        dcr_wr_data  = '0;
        if (write_fire) begin
            dcr_wr_addr = DCR_BASE + VX_DCR_ADDR_WIDTH'(wr_idx);
            dcr_wr_data = kmu_reg_value(desc_q, wr_idx);
        end
        launch_done = (state_q == WAIT) && hold_done && !kmu_busy;
        launch_err  = err_q;
    end

    always_comb begin
        hold_cnt_d = '0;
        if (state_q == WAIT) begin
            hold_cnt_d = hold_done ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
    end

    // Reset invalidates every shadow so the next launch rewrites all fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            desc_q       <= '0;
            dirty_q      <= '0;
            shadow_vld_q <= '0;
            hold_cnt_q   <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < KMU_NUM_CFG; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            err_q      <= reject;
            hold_cnt_q <= hold_cnt_d;
            if (accept) begin
                desc_q  <= in_desc;
                dirty_q <= new_dirty;
            end else if (write_fire) begin
                dirty_q[wr_idx] <= 1'b0;
                if (wr_idx < KMU_REG_START) begin
                    shadow_q[wr_idx]     <= kmu_reg_value(desc_q, wr_idx);
                    shadow_vld_q[wr_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_kmu_launch_writer.sv
// Scoreboard bench for the KMU launch writer: expected DCR writes (cycle offset, address, data)
// are queued when a launch is driven and popped as the DUT emits them.
module tb_vx_kmu_launch_writer;

    typedef struct {
        int          off;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] grid, blk;

    logic        l_vld32, rdy32, wv32, done32, err32, busy32;
    logic [31:0] pc32, prm32, wd32;
    logic [11:0] wa32;

    logic        l_vld64, rdy64, wv64, done64, err64, busy64;
    logic [63:0] pc64, prm64;
    logic [31:0] wd64;
    logic [11:0] wa64;

    wr_t exp32[$];
    wr_t exp64[$];
    int  n_cmp = 0, n_bad = 0, cyc = 0;
    int  t32 = 0, t64 = 0;
    int  n_wr64 = 0, n_done32 = 0, n_err32 = 0, n_err64 = 0;

    vx_kmu_launch_writer #(.XLEN(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .launch_valid(l_vld32), .launch_ready(rdy32),
        .launch_pc(pc32), .launch_grid_dim(grid), .launch_block_dim(blk), .launch_param(prm32),
        .dcr_wr_valid(wv32), .dcr_wr_addr(wa32), .dcr_wr_data(wd32),
        .kmu_busy(busy32), .launch_done(done32), .launch_err(err32)
    );

    vx_kmu_launch_writer #(.XLEN(64)) u_dut64 (
        .clk(clk), .reset(reset),
        .launch_valid(l_vld64), .launch_ready(rdy64),
        .launch_pc(pc64), .launch_grid_dim(grid), .launch_block_dim(blk), .launch_param(prm64),
        .dcr_wr_valid(wv64), .dcr_wr_addr(wa64), .dcr_wr_data(wd64),
        .kmu_busy(busy64), .launch_done(done64), .launch_err(err64)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wv32) begin
            if (exp32.size() == 0) begin
                check("wr32_extra_addr", 64'(wa32), 64'd0);
            end else begin
                wr_t e;
                e = exp32.pop_front();
                check("wr32_addr", 64'(wa32), 64'(e.addr));
                check("wr32_data", 64'(wd32), 64'(e.data));
                check("wr32_cyc", 64'(cyc - t32), 64'(e.off));
            end
        end
        if (done32) n_done32++;
        if (err32)  n_err32++;
    end

    always @(negedge clk) begin
        if (wv64) begin
            n_wr64++;
            if (exp64.size() == 0) begin
                check("wr64_extra_addr", 64'(wa64), 64'd0);
            end else begin
                wr_t e;
                e = exp64.pop_front();
                check("wr64_addr", 64'(wa64), 64'(e.addr));
                check("wr64_data", 64'(wd64), 64'(e.data));
                check("wr64_cyc", 64'(cyc - t64), 64'(e.off));
            end
        end
        if (err64) n_err64++;
    end

    task automatic push32(input int off, input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.off = off; e.addr = a; e.data = d;
        exp32.push_back(e);
    endtask

    task automatic push64(input int off, input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.off = off; e.addr = a; e.data = d;
        exp64.push_back(e);
    endtask

    // Presents the descriptor for exactly one cycle; t32 marks the handshake cycle.
    task automatic launch32(input logic [31:0] pc, input logic [31:0] gx, input logic [31:0] gy,
                            input logic [31:0] gz, input logic [31:0] bx, input logic [31:0] by,
                            input logic [31:0] bz, input logic [31:0] prm);
        @(posedge clk); #1;
        l_vld32 = 1'b1; pc32 = pc; prm32 = prm;
        grid = {gz, gy, gx}; blk = {bz, by, bx};
        @(negedge clk);
        check("launch32_ready", 64'(rdy32), 64'd1);
        t32 = cyc;
        @(posedge clk); #1;
        l_vld32 = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int exp_off, input string tag);
        logic seen;
        int   t;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel == 0 && done32) || (sel == 1 && done64)) begin
                seen = 1'b1;
                break;
            end
        end
        t = (sel == 0) ? t32 : t64;
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) check({tag, "_cyc"}, 64'(cyc - t), 64'(exp_off));
        @(negedge clk);
        check({tag, "_pulse"}, 64'((sel == 0) ? done32 : done64), 64'd0);
        check({tag, "_drain"}, 64'((sel == 0) ? exp32.size() : exp64.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        l_vld32 = 1'b0; l_vld64 = 1'b0; busy32 = 1'b0; busy64 = 1'b0;
        pc32 = '0; prm32 = '0; pc64 = '0; prm64 = '0; grid = '0; blk = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(rdy32), 64'd1);
        check("rst_wr_vld", 64'(wv32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_err", 64'(err32), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Cold launch: every field dirty
        push32(1, 12'h100, 32'h8000_0000); push32(2, 12'h102, 32'd4);
        push32(3, 12'h103, 32'd2);         push32(4, 12'h104, 32'd1);
        push32(5, 12'h105, 32'd32);        push32(6, 12'h106, 32'd1);
        push32(7, 12'h107, 32'd1);         push32(8, 12'h108, 32'h1000);
        push32(9, 12'h10A, 32'h1);
        launch32(32'h8000_0000, 4, 2, 1, 32, 1, 1, 32'h1000);
        wait_done(0, 12, "cold");

        // Only grid x changed
        push32(1, 12'h102, 32'd8); push32(2, 12'h10A, 32'h1);
        launch32(32'h8000_0000, 8, 2, 1, 32, 1, 1, 32'h1000);
        wait_done(0, 5, "gridx");

        // Zero dim is rejected without any write
        launch32(32'h8000_0000, 8, 2, 1, 32, 0, 1, 32'h1000);
        @(negedge clk);
        check("err_pulse", 64'(err32), 64'd1);
        check("err_ready", 64'(rdy32), 64'd1);
        @(negedge clk);
        check("err_one_cycle", 64'(err32), 64'd0);
        push32(1, 12'h106, 32'd5); push32(2, 12'h10A, 32'h1);
        launch32(32'h8000_0000, 8, 2, 1, 32, 5, 1, 32'h1000);
        wait_done(0, 5, "after_err");

        // Busy held 20 cycles after START; a launch offered during WAIT must be ignored
        busy32 = 1'b1;
        push32(1, 12'h10A, 32'h1);
        launch32(32'h8000_0000, 8, 2, 1, 32, 5, 1, 32'h1000);
        l_vld32 = 1'b1; grid = {32'd1, 32'd2, 32'd99};
        @(negedge clk);
        check("busy_ready_write", 64'(rdy32), 64'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("busy_ready_wait", 64'(rdy32), 64'd0);
        check("busy_no_done", 64'(done32), 64'd0);
        repeat (11) @(posedge clk);
        #1;
        busy32 = 1'b0; l_vld32 = 1'b0;
        wait_done(0, 22, "busy");

        // Reset lands in the cycle of the 4th write
        push32(1, 12'h100, 32'h400); push32(2, 12'h102, 32'd3); push32(3, 12'h103, 32'd3);
        launch32(32'h400, 3, 3, 3, 16, 2, 2, 32'h44);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_vld", 64'(wv32), 64'd0);
        check("midrst_ready", 64'(rdy32), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_drain", 64'(exp32.size()), 64'd0);
        push32(1, 12'h100, 32'h400); push32(2, 12'h102, 32'd3);
        push32(3, 12'h103, 32'd3);   push32(4, 12'h104, 32'd3);
        push32(5, 12'h105, 32'd16);  push32(6, 12'h106, 32'd2);
        push32(7, 12'h107, 32'd2);   push32(8, 12'h108, 32'h44);
        push32(9, 12'h10A, 32'h1);
        launch32(32'h400, 3, 3, 3, 16, 2, 2, 32'h44);
        wait_done(0, 12, "post_rst");

        // 64-bit PC and param split into LO/HI registers
        push64(1, 12'h100, 32'h2345_6780); push64(2, 12'h101, 32'h1);
        push64(3, 12'h102, 32'd1); push64(4, 12'h103, 32'd1); push64(5, 12'h104, 32'd1);
        push64(6, 12'h105, 32'd1); push64(7, 12'h106, 32'd1); push64(8, 12'h107, 32'd1);
        push64(9, 12'h108, 32'h0); push64(10, 12'h109, 32'h2); push64(11, 12'h10A, 32'h1);
        @(posedge clk); #1;
        l_vld64 = 1'b1; pc64 = 64'h1_2345_6780; prm64 = 64'h2_0000_0000;
        grid = {32'd1, 32'd1, 32'd1}; blk = {32'd1, 32'd1, 32'd1};
        @(negedge clk);
        check("x64_ready", 64'(rdy64), 64'd1);
        t64 = cyc;
        @(posedge clk); #1;
        l_vld64 = 1'b0;
        wait_done(1, 14, "x64");
        check("x64_write_count", 64'(n_wr64), 64'd11);

        check("total_done32", 64'(n_done32), 64'd5);
        check("total_err32", 64'(n_err32), 64'd1);
        check("total_err64", 64'(n_err64), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
